// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2
   } owner_e;

   localparam logic [1:0] MISALIGN_MASK = 2'b11;
   localparam int         DEF_ADDR_W    = 6;
   localparam int         DEF_DATA_W    = 32;

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester and memory-side signal bundle for imem_arbiter.
interface imem_arb_if
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_err;

   logic              ld_req;
   logic              ld_we;
   logic [31:0]       ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_err;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side: serves both requesters, drives the RAM.
   modport slave (
      input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      output ld_gnt, ld_rvalid, ld_rdata, ld_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   // Environment side: requesters plus the RAM model.
   modport master (
      output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_arbiter_addr_check.sv
// Byte address -> word index, with misalignment and out-of-range flags.
module imem_addr_check
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [31:0]       addr,
   output logic [ADDR_W-1:0] index,
   output logic              misaligned,
   output logic              out_of_range
);

   assign index        = addr[ADDR_W+1:2];
   assign misaligned   = (addr[1:0] & MISALIGN_MASK) != 2'b00;
   assign out_of_range = (addr >> (ADDR_W + 2)) != 32'd0;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a single-port 1-cycle-latency instruction RAM.
// Optional fetch stall counter enabled by IMEM_ARB_STALL_CNT_EN.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter bit LD_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   imem_arb_if.slave   bus
`ifdef IMEM_ARB_STALL_CNT_EN
   ,
   input  logic        stall_cnt_clr,
   output logic [31:0] fetch_stall_cnt
`endif
);

   logic [ADDR_W-1:0] f_idx, l_idx;
   logic              f_mis, f_oor, l_mis, l_oor;
   logic              f_bad, l_bad;
   logic              fetch_gnt, ld_gnt;

   owner_e            last_gnt, last_gnt_nxt;
   owner_e            resp_owner, resp_owner_nxt;
   logic              resp_err, resp_err_nxt;
   logic              resp_wr, resp_wr_nxt;

   logic [DATA_W-1:0] resp_data, fetch_hold, ld_hold;

   imem_addr_check #(.ADDR_W(ADDR_W)) u_fetch_chk (
      .addr         (bus.fetch_addr),
      .index        (f_idx),
      .misaligned   (f_mis),
      .out_of_range (f_oor)
   );

   imem_addr_check #(.ADDR_W(ADDR_W)) u_ld_chk (
      .addr         (bus.ld_addr),
      .index        (l_idx),
      .misaligned   (l_mis),
      .out_of_range (l_oor)
   );

   assign f_bad = f_mis | f_oor;
   assign l_bad = l_mis | l_oor;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
      fetch_gnt      = 1'b0;
      ld_gnt         = 1'b0;
      last_gnt_nxt   = last_gnt;
      resp_owner_nxt = NONE;
      resp_err_nxt   = 1'b0;
      resp_wr_nxt    = 1'b0;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;

      if (reset) begin
         if (bus.fetch_req && bus.ld_req) begin
            if (LD_PRIO || last_gnt == FETCH) ld_gnt    = 1'b1;
            else                              fetch_gnt = 1'b1;
         end else begin
            fetch_gnt = bus.fetch_req;
            ld_gnt    = bus.ld_req;
         end
      end

      // Bad addresses are still granted and answered, but never reach the RAM.
      if (fetch_gnt) begin
         last_gnt_nxt   = FETCH;
         resp_owner_nxt = FETCH;
         resp_err_nxt   = f_bad;
         bus.mem_en     = !f_bad;
         bus.mem_addr   = f_idx;
      end else if (ld_gnt) begin
         last_gnt_nxt   = LOAD;
         resp_owner_nxt = LOAD;
         resp_err_nxt   = l_bad;
         resp_wr_nxt    = bus.ld_we;
         bus.mem_en     = !l_bad;
         bus.mem_we     = !l_bad && bus.ld_we;
         bus.mem_addr   = l_idx;
         bus.mem_wdata  = bus.ld_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (!reset) begin
         last_gnt   <= LOAD;
         resp_owner <= NONE;
         resp_err   <= 1'b0;
         resp_wr    <= 1'b0;
         fetch_hold <= '0;
         ld_hold    <= '0;
      end else begin
         last_gnt   <= last_gnt_nxt;
         resp_owner <= resp_owner_nxt;
         resp_err   <= resp_err_nxt;
         resp_wr    <= resp_wr_nxt;
         if (bus.fetch_rvalid) fetch_hold <= resp_data;
         if (bus.ld_rvalid)    ld_hold    <= resp_data;
      end
   end

   // Write acks and errors return zero; reads pass the RAM output straight through.
   assign resp_data = (resp_err || resp_wr) ? '0 : bus.mem_rdata;

   assign bus.fetch_gnt    = fetch_gnt;
   assign bus.fetch_rvalid = (resp_owner == FETCH);
   assign bus.fetch_err    = bus.fetch_rvalid && resp_err;
   assign bus.fetch_rdata  = bus.fetch_rvalid ? resp_data : fetch_hold;

   assign bus.ld_gnt       = ld_gnt;
   assign bus.ld_rvalid    = (resp_owner == LOAD);
   assign bus.ld_err       = bus.ld_rvalid && resp_err;
   assign bus.ld_rdata     = bus.ld_rvalid ? resp_data : ld_hold;

`ifdef IMEM_ARB_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                                     fetch_stall_cnt <= '0;
      else if (stall_cnt_clr)                                         fetch_stall_cnt <= '0;
      else if (bus.fetch_req && !fetch_gnt && fetch_stall_cnt != '1)  fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one round-robin and one loader-priority instance.
module tb_imem_arbiter;
   import imem_arb_pkg::*;

   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) rr ();
   imem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) fp ();

   logic [DW-1:0] ram_rr [2**AW] = '{1: 32'h019806B3, default: 32'h0};
   logic [DW-1:0] ram_fp [2**AW] = '{default: 32'h0};

   always @(posedge clk) begin
      if (rr.mem_en) begin
         if (rr.mem_we) ram_rr[rr.mem_addr] <= rr.mem_wdata;
         else           rr.mem_rdata        <= ram_rr[rr.mem_addr];
      end
   end

   always @(posedge clk) begin
      if (fp.mem_en) begin
         if (fp.mem_we) ram_fp[fp.mem_addr] <= fp.mem_wdata;
         else           fp.mem_rdata        <= ram_fp[fp.mem_addr];
      end
   end

`ifdef IMEM_ARB_STALL_CNT_EN
   logic        clr_rr = 1'b0;
   logic        clr_fp = 1'b0;
   logic [31:0] cnt_rr, cnt_fp;
`endif

   imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LD_PRIO(1'b0)) u_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (rr)
`ifdef IMEM_ARB_STALL_CNT_EN
      ,
      .stall_cnt_clr   (clr_rr),
      .fetch_stall_cnt (cnt_rr)
`endif
   );

   imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LD_PRIO(1'b1)) u_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (fp)
`ifdef IMEM_ARB_STALL_CNT_EN
      ,
      .stall_cnt_clr   (clr_fp),
      .fetch_stall_cnt (cnt_fp)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rr.fetch_req = 1'b0; rr.fetch_addr = '0;
      rr.ld_req = 1'b0; rr.ld_we = 1'b0; rr.ld_addr = '0; rr.ld_wdata = '0;
      fp.fetch_req = 1'b0; fp.fetch_addr = '0;
      fp.ld_req = 1'b0; fp.ld_we = 1'b0; fp.ld_addr = '0; fp.ld_wdata = '0;

      // Reset state, with a request already pending
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h4;
      #2;
      check("rst_fetch_gnt", rr.fetch_gnt, 1'b0);
      check("rst_ld_gnt", rr.ld_gnt, 1'b0);
      check("rst_mem_en", rr.mem_en, 1'b0);
      check("rst_mem_we", rr.mem_we, 1'b0);
      check("rst_fetch_rvalid", rr.fetch_rvalid, 1'b0);
      check("rst_ld_rvalid", rr.ld_rvalid, 1'b0);
      check("rst_fetch_rdata", rr.fetch_rdata, 32'h0);
      check("rst_ld_rdata", rr.ld_rdata, 32'h0);
      repeat (2) cycle();
      reset = 1'b1;

      // 1: fetch read of word 1
      #1;
      check("t1_fetch_gnt", rr.fetch_gnt, 1'b1);
      check("t1_mem_en", rr.mem_en, 1'b1);
      check("t1_mem_we", rr.mem_we, 1'b0);
      check("t1_mem_addr", rr.mem_addr, 6'd1);
      check("t1_no_early_rvalid", rr.fetch_rvalid, 1'b0);
      cycle();
      rr.fetch_req = 1'b0;
      check("t1_fetch_rvalid", rr.fetch_rvalid, 1'b1);
      check("t1_fetch_rdata", rr.fetch_rdata, 32'h019806B3);
      check("t1_fetch_err", rr.fetch_err, 1'b0);
      cycle();
      check("t1_rvalid_drop", rr.fetch_rvalid, 1'b0);
      check("t1_rdata_hold", rr.fetch_rdata, 32'h019806B3);

      // 2: loader write to 0x2C, then fetch it back
      rr.ld_req = 1'b1; rr.ld_we = 1'b1; rr.ld_addr = 32'h2C; rr.ld_wdata = 32'h00948663;
      #1;
      check("t2_ld_gnt", rr.ld_gnt, 1'b1);
      check("t2_mem_we", rr.mem_we, 1'b1);
      check("t2_mem_addr", rr.mem_addr, 6'd11);
      check("t2_mem_wdata", rr.mem_wdata, 32'h00948663);
      cycle();
      rr.ld_req = 1'b0; rr.ld_we = 1'b0;
      check("t2_ld_rvalid", rr.ld_rvalid, 1'b1);
      check("t2_ld_rdata", rr.ld_rdata, 32'h0);
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h2C;
      #1;
      check("t2_fetch_gnt", rr.fetch_gnt, 1'b1);
      cycle();
      rr.fetch_req = 1'b0;
      check("t2_fetch_rvalid", rr.fetch_rvalid, 1'b1);
      check("t2_fetch_rdata", rr.fetch_rdata, 32'h00948663);

      // 3: round-robin under conflict, fresh from reset
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h4;
      rr.ld_req = 1'b1; rr.ld_we = 1'b0; rr.ld_addr = 32'h2C;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_fetch_gnt", rr.fetch_gnt, (i % 2) == 0);
         check("t3_ld_gnt", rr.ld_gnt, (i % 2) == 1);
         cycle();
         check("t3_fetch_rvalid", rr.fetch_rvalid, (i % 2) == 0);
         check("t3_ld_rvalid", rr.ld_rvalid, (i % 2) == 1);
         if (i % 2 == 0) check("t3_fetch_rdata", rr.fetch_rdata, 32'h019806B3);
         else            check("t3_ld_rdata", rr.ld_rdata, 32'h00948663);
      end
      rr.fetch_req = 1'b0; rr.ld_req = 1'b0;
      cycle();

      // 5: misaligned fetch, out-of-range loader write must not alias word 0
      rr.ld_req = 1'b1; rr.ld_we = 1'b1; rr.ld_addr = 32'h0; rr.ld_wdata = 32'h11111111;
      cycle();
      rr.ld_req = 1'b0;
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h6;
      #1;
      check("t5_fetch_gnt", rr.fetch_gnt, 1'b1);
      check("t5_mis_mem_en", rr.mem_en, 1'b0);
      cycle();
      rr.fetch_req = 1'b0;
      check("t5_fetch_rvalid", rr.fetch_rvalid, 1'b1);
      check("t5_fetch_err", rr.fetch_err, 1'b1);
      check("t5_fetch_rdata", rr.fetch_rdata, 32'h0);
      rr.ld_req = 1'b1; rr.ld_we = 1'b1; rr.ld_addr = 32'h100; rr.ld_wdata = 32'hDEADBEEF;
      #1;
      check("t5_ld_gnt", rr.ld_gnt, 1'b1);
      check("t5_oor_mem_en", rr.mem_en, 1'b0);
      check("t5_oor_mem_we", rr.mem_we, 1'b0);
      cycle();
      rr.ld_req = 1'b0; rr.ld_we = 1'b0;
      check("t5_ld_rvalid", rr.ld_rvalid, 1'b1);
      check("t5_ld_err", rr.ld_err, 1'b1);
      check("t5_ld_rdata", rr.ld_rdata, 32'h0);
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h0;
      cycle();
      rr.fetch_req = 1'b0;
      check("t5_word0_intact", rr.fetch_rdata, 32'h11111111);
      check("t5_word0_err", rr.fetch_err, 1'b0);

      // 6: reset lands between grant and response
      rr.fetch_req = 1'b1; rr.fetch_addr = 32'h4;
      #1;
      check("t6_fetch_gnt", rr.fetch_gnt, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_gnt_in_reset", rr.fetch_gnt, 1'b0);
      cycle();
      check("t6_no_rvalid", rr.fetch_rvalid, 1'b0);
      rr.fetch_req = 1'b0;
      cycle();
      reset = 1'b1;
      #1;
      check("t6_post_rst_fetch", rr.fetch_rvalid, 1'b0);
      cycle();
      check("t6_post_rst_fetch2", rr.fetch_rvalid, 1'b0);
      check("t6_post_rst_ld", rr.ld_rvalid, 1'b0);

      // 4: loader priority instance under sustained conflict
      fp.fetch_req = 1'b1; fp.fetch_addr = 32'h4;
      fp.ld_req = 1'b1; fp.ld_we = 1'b0; fp.ld_addr = 32'h2C;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_ld_gnt", fp.ld_gnt, 1'b1);
         check("t4_fetch_gnt", fp.fetch_gnt, 1'b0);
         cycle();
         check("t4_ld_rvalid", fp.ld_rvalid, 1'b1);
         check("t4_fetch_rvalid", fp.fetch_rvalid, 1'b0);
      end
`ifdef IMEM_ARB_STALL_CNT_EN
      check("t4_stall_cnt", cnt_fp, 32'd3);
      clr_fp = 1'b1;
      cycle();
      clr_fp = 1'b0;
      check("t4_stall_clr", cnt_fp, 32'd0);
`endif
      fp.fetch_req = 1'b0; fp.ld_req = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
